serial_receiver: RTL and testbench

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_receiver_pkg.sv | 12 +
 rtl/serial_receiver.sv | 79 +++++++
 tb/tb_serial_receiver.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the serial link: frame width and receive FSM encoding.
// Both ends of the link import this package.
package serial_receiver_pkg;

  localparam int FRAME_W = 40;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } rx_state_t;

endpackage

// File: rtl/serial_receiver.sv
// Serial frame receiver: start bit, then WIDTH payload bits LSB first, delivered
// through a one-word valid/ready holding register with a sticky overrun flag.
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int WIDTH = FRAME_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  // The completed word is the shifted value including the bit sampled this edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (sin) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end
      end
      DATA: begin
        shreg_nxt = {sin, shreg[WIDTH-1:1]};
        cnt_nxt   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completion is accepted when the holder is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      if (!out_valid || out_ready) begin
        out_data  <= shreg_nxt;
        out_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: single, back-to-back, backpressure,
// overrun, simultaneous accept/complete and mid-frame reset.
module tb_serial_receiver;
  import serial_receiver_pkg::*;

  localparam int W = FRAME_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         overrun;

  int total = 0;
  int bad = 0;
  logic [W-1:0] got[$];
  logic [W-1:0] partial;

  always #5 clk = ~clk;

  serial_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  // Record every word that completes a valid/ready handshake.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] got_at(input int idx);
    if (idx < got.size()) return got[idx];
    return 'x;
  endfunction

  task automatic send_payload(input logic [W-1:0] w, input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      sin = w[i];
      if (i == W - 1 && rdy_last) out_ready = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit rdy_last);
    @(negedge clk);
    sin = 1'b1;
    send_payload(w, rdy_last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin = 1'b0;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_bit("rst_valid", out_valid, 1'b0);
    check_bit("rst_overrun", overrun, 1'b0);
    check_word("rst_data", out_data, '0);
    rst_n = 1'b1;
    idle(2);

    // Single frame, consumer always ready
    out_ready = 1'b1;
    got.delete();
    send_frame(40'hD999999991, 1'b0);
    after_edge();
    check_bit("single_valid", out_valid, 1'b1);
    check_word("single_data", out_data, 40'hD999999991);
    check_bit("single_overrun", overrun, 1'b0);
    idle(1);
    after_edge();
    check_bit("single_valid_drop", out_valid, 1'b0);
    check_int("single_count", got.size(), 1);

    // Back-to-back zero-gap frames
    got.delete();
    send_frame(40'h0000000001, 1'b0);
    send_frame(40'h8000000000, 1'b0);
    idle(3);
    check_int("b2b_count", got.size(), 2);
    check_word("b2b_first", got_at(0), 40'h0000000001);
    check_word("b2b_second", got_at(1), 40'h8000000000);
    check_bit("b2b_valid_end", out_valid, 1'b0);
    check_bit("b2b_overrun", overrun, 1'b0);

    // Backpressure: word held until the consumer is ready
    out_ready = 1'b0;
    got.delete();
    send_frame(40'h123456789A, 1'b0);
    after_edge();
    check_bit("bp_valid", out_valid, 1'b1);
    check_word("bp_data", out_data, 40'h123456789A);
    for (int c = 0; c < 5; c++) begin
      idle(1);
      after_edge();
      check_bit("bp_hold_valid", out_valid, 1'b1);
      check_word("bp_hold_data", out_data, 40'h123456789A);
    end
    @(negedge clk);
    out_ready = 1'b1;
    after_edge();
    check_bit("bp_release_valid", out_valid, 1'b0);
    check_int("bp_count", got.size(), 1);
    check_word("bp_word", got_at(0), 40'h123456789A);

    // Overrun: second word dropped, flag sticky
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(40'hAAAAAAAAAA, 1'b0);
    send_frame(40'h5555555555, 1'b0);
    after_edge();
    check_bit("ovr_valid", out_valid, 1'b1);
    check_word("ovr_data", out_data, 40'hAAAAAAAAAA);
    check_bit("ovr_flag", overrun, 1'b1);
    @(negedge clk);
    sin = 1'b0;
    out_ready = 1'b1;
    after_edge();
    check_bit("ovr_drain_valid", out_valid, 1'b0);
    check_bit("ovr_sticky1", overrun, 1'b1);
    idle(4);
    check_bit("ovr_sticky2", overrun, 1'b1);
    do_reset();
    check_bit("ovr_reset_clear", overrun, 1'b0);

    // Completion in the same cycle the previous word is accepted
    out_ready = 1'b0;
    got.delete();
    send_frame(40'h0F0F0F0F0F, 1'b0);
    send_frame(40'h3C3C3C3C3C, 1'b1);
    after_edge();
    check_bit("sim_valid", out_valid, 1'b1);
    check_word("sim_data", out_data, 40'h3C3C3C3C3C);
    check_bit("sim_overrun", overrun, 1'b0);
    check_int("sim_count", got.size(), 1);
    check_word("sim_first", got_at(0), 40'h0F0F0F0F0F);
    idle(1);
    after_edge();
    check_bit("sim_drain_valid", out_valid, 1'b0);

    // Mid-frame reset, then a frame whose start bit lands on the first clk out of reset
    got.delete();
    out_ready = 1'b1;
    partial = 40'hA5A5A5A5A5;
    @(negedge clk);
    sin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sin = partial[i];
    end
    @(negedge clk);
    rst_n = 1'b0;
    sin = 1'b0;
    @(negedge clk);
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check_word("mid_rst_data", out_data, '0);
    rst_n = 1'b1;
    sin = 1'b1;
    send_payload(40'hFFFFFFFFFF, 1'b0);
    after_edge();
    check_bit("mid_valid", out_valid, 1'b1);
    check_word("mid_data", out_data, 40'hFFFFFFFFFF);
    idle(3);
    check_int("mid_count", got.size(), 1);
    check_word("mid_word", got_at(0), 40'hFFFFFFFFFF);
    check_bit("mid_overrun", overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
